// File: rtl/ex_muldiv_seq_if.sv
// EX-stage to multiply/divide sequencer bundle: request, operands, stall and tagged result.
interface ex_muldiv_seq_if #(
    parameter int unsigned XLEN = 32
);
    logic            start_i;
    logic [2:0]      op_i;
    logic [XLEN-1:0] src_A_i;
    logic [XLEN-1:0] src_B_i;
    logic [4:0]      rd_i;
    logic            flush_i;
    logic            stall_o;
    logic            done_o;
    logic [XLEN-1:0] result_o;
    logic [4:0]      rd_o;

    modport master (
        output start_i, op_i, src_A_i, src_B_i, rd_i, flush_i,
        input  stall_o, done_o, result_o, rd_o
    );

    modport slave (
        input  start_i, op_i, src_A_i, src_B_i, rd_i, flush_i,
        output stall_o, done_o, result_o, rd_o
    );
endinterface

// File: rtl/ex_muldiv_seq.sv
// Iterative RV32M sequencer: 32-step shift-add multiply / restoring divide on operand magnitudes,
// a sign fix-up cycle, and a fast path for divide-by-zero and signed overflow.
module ex_muldiv_seq #(
    parameter int unsigned XLEN = 32
) (
    input logic               clk_i,
    input logic               rst_n_i,
    ex_muldiv_seq_if.slave    bus
);
    localparam int unsigned CntW = $clog2(XLEN);
    localparam logic [CntW-1:0] LastCnt = CntW'(XLEN - 1);
    localparam logic [XLEN-1:0] AllOnes = {XLEN{1'b1}};
    localparam logic [XLEN-1:0] MinNeg  = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {StIdle, StCalc, StFix, StDone} state_e;

    state_e            state_q, state_d;
    logic [2:0]        op_q, op_d;
    logic [4:0]        rd_q, rd_d;
    logic [XLEN-1:0]   opnd_q, opnd_d;
    logic [2*XLEN-1:0] acc_q, acc_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic              sa_q, sa_d;
    logic              sb_q, sb_d;
    logic [XLEN-1:0]   result_q, result_d;
    logic [4:0]        rd_out_q, rd_out_d;

    // Operand decode at accept time.
    logic            in_div, in_signed_a, in_signed_b, in_sa, in_sb, in_div_zero, in_div_ovf;
    logic [XLEN-1:0] mag_a, mag_b;

    always_comb begin
        in_div      = bus.op_i[2];
        in_signed_a = (bus.op_i == 3'b001) || (bus.op_i == 3'b010) || (in_div && !bus.op_i[0]);
        in_signed_b = (bus.op_i == 3'b001) || (in_div && !bus.op_i[0]);
        in_sa       = in_signed_a && bus.src_A_i[XLEN-1];
        in_sb       = in_signed_b && bus.src_B_i[XLEN-1];
        mag_a       = in_sa ? -bus.src_A_i : bus.src_A_i;
        mag_b       = in_sb ? -bus.src_B_i : bus.src_B_i;
        in_div_zero = in_div && (bus.src_B_i == '0);
        in_div_ovf  = in_div && !bus.op_i[0] && (bus.src_A_i == MinNeg) && (bus.src_B_i == AllOnes);
    end

    // Multiply: acc = {partial high, remaining multiplier}; divide: acc = {remainder, dividend/quotient}.
    logic [XLEN:0]     mul_sum, div_shift, div_diff;
    logic [2*XLEN-1:0] mul_step, div_step, prod_fix;
    logic [XLEN-1:0]   quo_fix, rem_fix, fix_result;

    always_comb begin
        mul_sum   = {1'b0, acc_q[2*XLEN-1:XLEN]} + {1'b0, (acc_q[0] ? opnd_q : '0)};
        mul_step  = {mul_sum, acc_q[XLEN-1:1]};
        div_shift = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
        div_diff  = div_shift - {1'b0, opnd_q};
        div_step  = div_diff[XLEN] ? {div_shift[XLEN-1:0], acc_q[XLEN-2:0], 1'b0}
                                   : {div_diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
        prod_fix  = (sa_q ^ sb_q) ? -acc_q : acc_q;
        quo_fix   = (sa_q ^ sb_q) ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
        rem_fix   = sa_q ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];
        unique case (op_q)
            3'b000:                 fix_result = prod_fix[XLEN-1:0];
            3'b001, 3'b010, 3'b011: fix_result = prod_fix[2*XLEN-1:XLEN];
            3'b100, 3'b101:         fix_result = quo_fix;
            default:                fix_result = rem_fix;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        rd_d     = rd_q;
        opnd_d   = opnd_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        sa_d     = sa_q;
        sb_d     = sb_q;
        result_d = result_q;
        rd_out_d = rd_out_q;
        unique case (state_q)
            StIdle: begin
                if (bus.start_i && !bus.flush_i) begin
                    op_d  = bus.op_i;
                    rd_d  = bus.rd_i;
                    sa_d  = in_sa;
                    sb_d  = in_sb;
                    cnt_d = '0;
                    if (in_div) begin
                        acc_d  = {{XLEN{1'b0}}, mag_a};
                        opnd_d = mag_b;
                    end else begin
                        acc_d  = {{XLEN{1'b0}}, mag_b};
                        opnd_d = mag_a;
                    end
                    if (in_div_zero) begin
                        result_d = bus.op_i[1] ? bus.src_A_i : AllOnes;
                        rd_out_d = bus.rd_i;
                        state_d  = StDone;
                    end else if (in_div_ovf) begin
                        result_d = bus.op_i[1] ? '0 : MinNeg;
                        rd_out_d = bus.rd_i;
                        state_d  = StDone;
                    end else begin
                        state_d = StCalc;
                    end
                end
            end
            StCalc: begin
                if (bus.flush_i) begin
                    state_d = StIdle;
                end else begin
                    acc_d = op_q[2] ? div_step : mul_step;
                    cnt_d = cnt_q + CntW'(1);
                    if (cnt_q == LastCnt) state_d = StFix;
                end
            end
            StFix: begin
                if (bus.flush_i) begin
                    state_d = StIdle;
                end else begin
                    result_d = fix_result;
                    rd_out_d = rd_q;
                    state_d  = StDone;
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q  <= StIdle;
            op_q     <= '0;
            rd_q     <= '0;
            opnd_q   <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            sa_q     <= 1'b0;
            sb_q     <= 1'b0;
            result_q <= '0;
            rd_out_q <= '0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            rd_q     <= rd_d;
            opnd_q   <= opnd_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            sa_q     <= sa_d;
            sb_q     <= sb_d;
            result_q <= result_d;
            rd_out_q <= rd_out_d;
        end
    end

    assign bus.stall_o  = (state_q == StCalc) || (state_q == StFix);
    assign bus.done_o   = (state_q == StDone);
    assign bus.result_o = result_q;
    assign bus.rd_o     = rd_out_q;
endmodule

// File: tb/tb_ex_muldiv_seq.sv
// Bench for ex_muldiv_seq: directed literal vectors plus randomized traffic against an
// arithmetic/timing reference model checked on every cycle.
module tb_ex_muldiv_seq;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    ex_muldiv_seq_if #(.XLEN(32)) bus ();
    ex_muldiv_seq #(.XLEN(32)) dut (.clk_i(clk), .rst_n_i(rst_n), .bus(bus));

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] ref_op(input logic [2:0] op, input logic [31:0] a,
                                           input logic [31:0] b);
        longint    sa64 = longint'($signed(a));
        longint    sb64 = longint'($signed(b));
        longint    ua64 = longint'({32'd0, a});
        longint    ub64 = longint'({32'd0, b});
        int        ai   = $signed(a);
        int        bi   = $signed(b);
        logic [63:0] p;
        logic [31:0] r;
        logic        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        case (op)
            3'd0: begin p = 64'(ua64 * ub64); r = p[31:0]; end
            3'd1: begin p = 64'(sa64 * sb64); r = p[63:32]; end
            3'd2: begin p = 64'(sa64 * ub64); r = p[63:32]; end
            3'd3: begin p = 64'(ua64 * ub64); r = p[63:32]; end
            3'd4: r = (b == 0) ? 32'hFFFF_FFFF : ovf ? 32'h8000_0000 : 32'(ai / bi);
            3'd5: r = (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: r = (b == 0) ? a : ovf ? 32'd0 : 32'(ai % bi);
            default: r = (b == 0) ? a : a % b;
        endcase
        return r;
    endfunction

    function automatic bit is_fast(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        return op[2] && ((b == 0) || (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
    endfunction

    // Reference model: outstanding stall cycles, a pending done pulse, and the committed result.
    bit          m_valid = 1'b0;
    int          m_left  = 0;
    bit          m_done  = 1'b0;
    logic [31:0] m_res, m_pend;
    logic [4:0]  m_rd, m_pend_rd;

    always @(posedge clk) begin
        if (!rst_n) begin
            m_valid <= 1'b1;
            m_left  <= 0;
            m_done  <= 1'b0;
            m_res   <= '0;
            m_rd    <= '0;
        end else if (m_valid) begin
            if (m_done) begin
                m_done <= 1'b0;
            end else if (m_left > 0) begin
                if (bus.flush_i) begin
                    m_left <= 0;
                end else begin
                    m_left <= m_left - 1;
                    if (m_left == 1) begin
                        m_done <= 1'b1;
                        m_res  <= m_pend;
                        m_rd   <= m_pend_rd;
                    end
                end
            end else if (bus.start_i && !bus.flush_i) begin
                m_pend    <= ref_op(bus.op_i, bus.src_A_i, bus.src_B_i);
                m_pend_rd <= bus.rd_i;
                if (is_fast(bus.op_i, bus.src_A_i, bus.src_B_i)) begin
                    m_done <= 1'b1;
                    m_res  <= ref_op(bus.op_i, bus.src_A_i, bus.src_B_i);
                    m_rd   <= bus.rd_i;
                end else begin
                    m_left <= 33;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (m_valid) begin
            check("stall", 32'(bus.stall_o), 32'(m_left > 0));
            check("done", 32'(bus.done_o), 32'(m_done));
            check("result", bus.result_o, m_res);
            check("rd", 32'(bus.rd_o), 32'(m_rd));
        end
    end

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        int          lat;
    } vec_t;

    vec_t vecs[12] = '{
        '{3'd0, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, 34},
        '{3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 34},
        '{3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 34},
        '{3'd2, 32'hFFFF_FFFF, 32'd2,          32'hFFFF_FFFF, 34},
        '{3'd5, 32'd100,        32'd7,          32'd14,        34},
        '{3'd7, 32'd100,        32'd7,          32'd2,         34},
        '{3'd4, 32'hFFFF_FFF9, 32'd2,          32'hFFFF_FFFD, 34},
        '{3'd6, 32'hFFFF_FFF9, 32'd2,          32'hFFFF_FFFF, 34},
        '{3'd4, 32'd5,          32'd0,          32'hFFFF_FFFF, 1},
        '{3'd6, 32'd5,          32'd0,          32'd5,         1},
        '{3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1},
        '{3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         1}
    };

    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] rd, input logic [31:0] exp, input int lat);
        int  n      = 0;
        int  stalls = 0;
        bit  seen   = 1'b0;
        check("model_pin", ref_op(op, a, b), exp);
        @(negedge clk);
        bus.start_i = 1'b1;
        bus.op_i    = op;
        bus.src_A_i = a;
        bus.src_B_i = b;
        bus.rd_i    = rd;
        while (!seen && n < 40) begin
            @(negedge clk);
            n++;
            if (n == 1) begin
                bus.start_i = 1'b0;
                bus.src_A_i = $urandom;
                bus.src_B_i = $urandom;
                bus.rd_i    = 5'($urandom);
            end
            if (bus.stall_o) stalls++;
            if (bus.done_o) seen = 1'b1;
        end
        check("done_seen", 32'(seen), 32'd1);
        check("latency", 32'(n), 32'(lat));
        check("stall_cycles", 32'(stalls), 32'(lat - 1));
        check("op_result", bus.result_o, exp);
        check("op_rd", 32'(bus.rd_o), 32'(rd));
    endtask

    function automatic logic [31:0] rnd_operand();
        case ($urandom_range(0, 5))
            0:       return 32'd0;
            1:       return 32'h8000_0000;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        int dones;
        rst_n       = 1'b0;
        bus.start_i = 1'b0;
        bus.flush_i = 1'b0;
        bus.op_i    = '0;
        bus.src_A_i = '0;
        bus.src_B_i = '0;
        bus.rd_i    = '0;
        repeat (3) @(negedge clk);
        check("reset_result", bus.result_o, 32'd0);
        check("reset_stall", 32'(bus.stall_o), 32'd0);
        rst_n = 1'b1;

        for (int i = 0; i < 12; i++) begin
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, 5'(3 * i + 1), vecs[i].exp, vecs[i].lat);
        end

        // Flush a DIVU at counter 10: no done, result keeps the last committed value (REM -> 0).
        @(negedge clk);
        bus.start_i = 1'b1;
        bus.op_i    = 3'd5;
        bus.src_A_i = 32'd1000;
        bus.src_B_i = 32'd3;
        bus.rd_i    = 5'd9;
        for (int i = 1; i <= 11; i++) begin
            @(negedge clk);
            if (i == 1) bus.start_i = 1'b0;
        end
        bus.flush_i = 1'b1;
        @(negedge clk);
        bus.flush_i = 1'b0;
        check("flush_stall", 32'(bus.stall_o), 32'd0);
        dones = 0;
        repeat (40) begin
            @(negedge clk);
            if (bus.done_o) dones++;
        end
        check("flush_no_done", 32'(dones), 32'd0);
        check("flush_result_kept", bus.result_o, 32'd0);
        run_op(3'd0, 32'd3, 32'd4, 5'd17, 32'd12, 34);

        // start held high with changing operands: back-to-back ops, start during done ignored.
        @(negedge clk);
        bus.start_i = 1'b1;
        repeat (120) begin
            bus.op_i    = 3'($urandom);
            bus.src_A_i = rnd_operand();
            bus.src_B_i = rnd_operand();
            bus.rd_i    = 5'($urandom);
            @(negedge clk);
        end
        bus.start_i = 1'b0;
        repeat (40) @(negedge clk);

        // Reset in the middle of CALC.
        bus.start_i = 1'b1;
        bus.op_i    = 3'd1;
        bus.src_A_i = 32'h1234_5678;
        bus.src_B_i = 32'h9ABC_DEF0;
        bus.rd_i    = 5'd21;
        @(negedge clk);
        bus.start_i = 1'b0;
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("rst_mid_stall", 32'(bus.stall_o), 32'd0);
        check("rst_mid_done", 32'(bus.done_o), 32'd0);
        check("rst_mid_result", bus.result_o, 32'd0);
        check("rst_mid_rd", 32'(bus.rd_o), 32'd0);

        // Randomized traffic with occasional flush and reset.
        repeat (4000) begin
            rst_n       = ($urandom_range(0, 499) != 0);
            bus.start_i = ($urandom_range(0, 2) == 0);
            bus.flush_i = ($urandom_range(0, 79) == 0);
            bus.op_i    = 3'($urandom);
            bus.src_A_i = rnd_operand();
            bus.src_B_i = rnd_operand();
            bus.rd_i    = 5'($urandom);
            @(negedge clk);
        end
        rst_n       = 1'b1;
        bus.start_i = 1'b0;
        bus.flush_i = 1'b0;
        repeat (40) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
